// File: rtl/rtype_instr_writer_pkg.sv
// rtl/rtype_instr_writer_pkg.sv - shared R-type opcode, funct and FSM encodings
// The decoder and writer both import this package so the two funct tables cannot drift apart.
package rtype_instr_writer_pkg;

  localparam logic [2:0] AOP_AND  = 3'b000;
  localparam logic [2:0] AOP_OR   = 3'b001;
  localparam logic [2:0] AOP_XOR  = 3'b010;
  localparam logic [2:0] AOP_NOR  = 3'b011;
  localparam logic [2:0] AOP_ADD  = 3'b100;
  localparam logic [2:0] AOP_SUB  = 3'b101;
  localparam logic [2:0] AOP_SLTU = 3'b110;
  localparam logic [2:0] AOP_SLLV = 3'b111;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // shamt is never used by this ALU, so it is always packed as zero
  function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

endpackage

// File: rtl/rtype_encode.sv
// rtl/rtype_encode.sv - combinational ALU-op plus register fields to R-type word
module rtype_encode
  import rtype_instr_writer_pkg::*;
(
  input  logic [2:0]  aop,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [31:0] word
);

  logic [5:0] funct;

  always_comb begin
    funct = FUNCT_ADD;
    case (aop)
      AOP_ADD:  funct = FUNCT_ADD;
      AOP_SUB:  funct = FUNCT_SUB;
      AOP_AND:  funct = FUNCT_AND;
      AOP_OR:   funct = FUNCT_OR;
      AOP_XOR:  funct = FUNCT_XOR;
      AOP_NOR:  funct = FUNCT_NOR;
      AOP_SLTU: funct = FUNCT_SLTU;
      AOP_SLLV: funct = FUNCT_SLLV;
    endcase
  end

  assign word = rtype_word(rs, rt, rd, funct);

endmodule

// File: rtl/rtype_instr_writer.sv
// rtl/rtype_instr_writer.sv - encodes R-type requests and writes them to sequential instruction-memory words
module rtype_instr_writer
  import rtype_instr_writer_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   in_aop,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic                         mem_ack,
  output logic [$clog2(MAX_WORDS):0]   word_count,
  output logic                         full
);

  localparam int CNT_W = $clog2(MAX_WORDS) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

  logic [1:0]       state;
  logic [31:0]      enc_word;
  logic [CNT_W-1:0] count_next;

  rtype_encode u_encode (
    .aop  (in_aop),
    .rs   (in_rs),
    .rt   (in_rt),
    .rd   (in_rd),
    .word (enc_word)
  );

  // Strobes decode straight from state so a reset mid-write drops mem_we without waiting for an edge
  assign in_ready   = (state == ST_IDLE);
  assign mem_we     = (state == ST_WRITE);
  assign full       = (state == ST_FULL);
  assign count_next = word_count + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      word_count <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      mem_addr   <= BASE;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mem_wdata <= enc_word;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_addr   <= mem_addr + WORD_INC;
            word_count <= count_next;
            state      <= (count_next == CNT_MAX) ? ST_FULL : ST_IDLE;
          end
        end
        ST_FULL: begin
          state <= ST_FULL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
